ps2_mouse_packet: RTL and testbench

Downstream consumer of the PS/2 mouse controller's byte stream. It assembles received bytes into standard 3-byte stream-mode packets and checks packet framing. For each complete packet it emits signed X/Y deltas and button state, and it keeps a clamped cursor position for the Paint canvas. It sits between the PS/2 mouse controller (`rx_data`/`rx_data_valid`/`init_done`) and the drawing logic.

---
 rtl/ps2_pkg.sv | 31 +++
 rtl/ps2_axis_accum.sv | 43 ++++
 rtl/ps2_mouse_packet.sv | 141 ++++++++++++++
 tb/tb_ps2_mouse_packet.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and byte-0 field positions for the PS/2 mouse packet decoder.
// No logic; imported by the decoder and its axis accumulators.
// No flow control of its own.
package ps2_pkg;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2
    } ps2_state_t;

    localparam int SYNC_BIT = 3;
    localparam int XS_BIT   = 4;
    localparam int YS_BIT   = 5;
    localparam int XO_BIT   = 6;
    localparam int YO_BIT   = 7;

    localparam int BTN_LEFT   = 0;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_MIDDLE = 2;

    // Only the byte-0 fields needed after byte 0 has been accepted.
    typedef struct packed {
        logic       yo;
        logic       xo;
        logic       ys;
        logic       xs;
        logic [2:0] btn;
    } b0_t;

endpackage

// File: rtl/ps2_axis_accum.sv
// Saturating cursor-axis accumulator: pos += delta (or -= delta), clamped to [0, MAX].
// Latency: one cycle from add_en_i to pos_o.
// Backpressure: none; one update per add_en_i strobe.
module ps2_axis_accum #(
    parameter int MAX  = 639,
    parameter int INIT = 320
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             add_en_i,
    input  logic             sub_i,
    input  logic signed [8:0] delta_i,
    output logic [9:0]       pos_o
);

    logic [9:0]        pos_q, pos_d;
    logic signed [11:0] pos_ext, delta_ext, sum;

    always_comb begin
        pos_ext   = $signed({2'b00, pos_q});
        delta_ext = {{3{delta_i[8]}}, delta_i};
        sum       = sub_i ? (pos_ext - delta_ext) : (pos_ext + delta_ext);
        pos_d     = pos_q;
        if (add_en_i) begin
            if (sum < 0)
                pos_d = '0;
            else if (sum > $signed(12'(MAX)))
                pos_d = 10'(MAX);
            else
                pos_d = sum[9:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pos_q <= 10'(INIT);
        else
            pos_q <= pos_d;
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/ps2_mouse_packet.sv
// Assembles 3-byte PS/2 stream packets into deltas/buttons and a clamped cursor position.
// Latency: outputs register one cycle after byte 2; sync_err one cycle after bad byte/timeout.
// Backpressure: none; accepts a byte every cycle, bytes ignored while enable is low.
module ps2_mouse_packet
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TIMEOUT_US  = 2000,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int X_INIT      = 320,
    parameter int Y_INIT      = 240
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       pkt_valid,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic [2:0] btn,
    output logic       ovf,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       sync_err
);

    localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
    localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_t       state_q;
    b0_t              b0_q;
    logic [7:0]       b1_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pkt_valid_q, sync_err_q, ovf_q;
    logic [8:0]       dx_q, dy_q;
    logic [2:0]       btn_q;

    logic             take_b2, timeout;
    logic signed [8:0] x_delta, y_delta;

    assign take_b2 = enable && rx_valid && (state_q == WAIT_B2);
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !rx_valid;

    // An overflowed axis contributes nothing to the cursor.
    assign x_delta = b0_q.xo ? 9'sd0 : $signed({b0_q.xs, b1_q});
    assign y_delta = b0_q.yo ? 9'sd0 : $signed({b0_q.ys, rx_data});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_B0;
            b0_q        <= '0;
            b1_q        <= '0;
            cnt_q       <= '0;
            pkt_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            dx_q        <= '0;
            dy_q        <= '0;
            btn_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            pkt_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            if (!enable) begin
                state_q <= WAIT_B0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    WAIT_B0: begin
                        cnt_q <= '0;
                        if (rx_valid) begin
                            if (rx_data[SYNC_BIT]) begin
                                b0_q    <= '{yo: rx_data[YO_BIT], xo: rx_data[XO_BIT],
                                             ys: rx_data[YS_BIT], xs: rx_data[XS_BIT],
                                             btn: rx_data[2:0]};
                                state_q <= WAIT_B1;
                            end else begin
                                sync_err_q <= 1'b1;
                            end
                        end
                    end
                    WAIT_B1, WAIT_B2: begin
                        if (rx_valid) begin
                            cnt_q <= '0;
                            if (state_q == WAIT_B1) begin
                                b1_q    <= rx_data;
                                state_q <= WAIT_B2;
                            end else begin
                                dx_q        <= {b0_q.xs, b1_q};
                                dy_q        <= {b0_q.ys, rx_data};
                                btn_q       <= {b0_q.btn[BTN_MIDDLE], b0_q.btn[BTN_RIGHT],
                                                b0_q.btn[BTN_LEFT]};
                                ovf_q       <= b0_q.xo | b0_q.yo;
                                pkt_valid_q <= 1'b1;
                                state_q     <= WAIT_B0;
                            end
                        end else if (timeout) begin
                            cnt_q      <= '0;
                            sync_err_q <= 1'b1;
                            state_q    <= WAIT_B0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= WAIT_B0;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    ps2_axis_accum #(.MAX(X_MAX), .INIT(X_INIT)) u_x_accum (
        .clk      (clk),
        .rst_n    (rst_n),
        .add_en_i (take_b2),
        .sub_i    (1'b0),
        .delta_i  (x_delta),
        .pos_o    (x_pos)
    );

    // PS/2 Y is positive-up, screen Y is positive-down.
    ps2_axis_accum #(.MAX(Y_MAX), .INIT(Y_INIT)) u_y_accum (
        .clk      (clk),
        .rst_n    (rst_n),
        .add_en_i (take_b2),
        .sub_i    (1'b1),
        .delta_i  (y_delta),
        .pos_o    (y_pos)
    );

    assign pkt_valid = pkt_valid_q;
    assign sync_err  = sync_err_q;
    assign dx        = dx_q;
    assign dy        = dy_q;
    assign btn       = btn_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Directed bench for ps2_mouse_packet with a 20-cycle byte timeout.
module tb_ps2_mouse_packet;

    localparam int T_CYC = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       pkt_valid;
    logic [8:0] dx, dy;
    logic [2:0] btn;
    logic       ovf;
    logic [9:0] x_pos, y_pos;
    logic       sync_err;

    int n_tests = 0;
    int n_fail  = 0;
    int pkt_cnt = 0;
    int err_cnt = 0;
    int pkt_base, err_base;

    ps2_mouse_packet #(
        .CLK_FREQ_HZ (1_000_000),
        .TIMEOUT_US  (T_CYC),
        .X_MAX       (639),
        .Y_MAX       (479),
        .X_INIT      (320),
        .Y_INIT      (240)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .pkt_valid (pkt_valid),
        .dx        (dx),
        .dy        (dy),
        .btn       (btn),
        .ovf       (ovf),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pkt_valid) pkt_cnt++;
        if (sync_err)  err_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one byte for exactly one cycle; returns 1 time unit after the sampling edge.
    task automatic drive(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mark();
        pkt_base = pkt_cnt;
        err_base = err_cnt;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        idle(3);
        chk("rst_pkt_valid", int'(pkt_valid), 0);
        chk("rst_sync_err",  int'(sync_err), 0);
        chk("rst_dx",        int'($signed(dx)), 0);
        chk("rst_dy",        int'($signed(dy)), 0);
        chk("rst_btn",       int'(btn), 0);
        chk("rst_ovf",       int'(ovf), 0);
        chk("rst_x",         int'(x_pos), 320);
        chk("rst_y",         int'(y_pos), 240);
        rst_n  = 1'b1;
        enable = 1'b1;
        idle(1);

        // Y sign bit set so byte 2 = 0xFE reads as dy = -2.
        drive(8'h29); drive(8'h05); drive(8'hFE);
        chk("p1_pkt_valid", int'(pkt_valid), 1);
        chk("p1_dx",        int'($signed(dx)), 5);
        chk("p1_dy",        int'($signed(dy)), -2);
        chk("p1_btn",       int'(btn), 1);
        chk("p1_x",         int'(x_pos), 325);
        chk("p1_y",         int'(y_pos), 242);
        idle(1);
        chk("p1_pkt_once",  int'(pkt_valid), 0);

        do_reset();
        mark();
        drive(8'h18); drive(8'h00); drive(8'h00);
        chk("neg1_dx", int'($signed(dx)), -256);
        chk("neg1_x",  int'(x_pos), 64);
        idle(1);
        drive(8'h18); drive(8'h00); drive(8'h00);
        chk("neg2_x_sat0", int'(x_pos), 0);
        chk("neg2_y",      int'(y_pos), 240);
        idle(1);
        chk("neg_no_err",  err_cnt - err_base, 0);
        chk("neg_pkts",    pkt_cnt - pkt_base, 2);

        mark();
        enable = 1'b0;
        drive(8'hFA); drive(8'h08); drive(8'h01); drive(8'h01);
        idle(2);
        enable = 1'b1;
        idle(2);
        chk("dis_no_pkt", pkt_cnt - pkt_base, 0);
        chk("dis_no_err", err_cnt - err_base, 0);
        chk("dis_x",      int'(x_pos), 0);
        chk("dis_y",      int'(y_pos), 240);

        // 0x00 is only rejected if the FSM really sits in WAIT_B0.
        mark();
        drive(8'h00);
        chk("stray_err", int'(sync_err), 1);
        idle(1);
        drive(8'h08); drive(8'h01); drive(8'h01);
        chk("rs_dx", int'($signed(dx)), 1);
        chk("rs_dy", int'($signed(dy)), 1);
        chk("rs_x",  int'(x_pos), 1);
        chk("rs_y",  int'(y_pos), 239);
        idle(1);
        chk("rs_pkts", pkt_cnt - pkt_base, 1);
        chk("rs_errs", err_cnt - err_base, 1);

        mark();
        drive(8'h08); drive(8'h01);
        idle(T_CYC - 1);
        chk("to_early", int'(sync_err), 0);
        idle(1);
        chk("to_err", int'(sync_err), 1);
        idle(3);
        chk("to_no_pkt", pkt_cnt - pkt_base, 0);
        chk("to_errs",   err_cnt - err_base, 1);

        mark();
        drive(8'h08); drive(8'h01);
        idle(T_CYC - 1);
        drive(8'h02);
        chk("edge_pkt", int'(pkt_valid), 1);
        chk("edge_dy",  int'($signed(dy)), 2);
        chk("edge_x",   int'(x_pos), 2);
        chk("edge_y",   int'(y_pos), 237);
        idle(2);
        chk("edge_no_err", err_cnt - err_base, 0);

        drive(8'h48); drive(8'h7F); drive(8'h10);
        chk("ovf_flag", int'(ovf), 1);
        chk("ovf_dx",   int'($signed(dx)), 127);
        chk("ovf_dy",   int'($signed(dy)), 16);
        chk("ovf_x",    int'(x_pos), 2);
        chk("ovf_y",    int'(y_pos), 221);
        idle(1);

        drive(8'h08);
        rst_n = 1'b0;
        #1;
        chk("ar_x",   int'(x_pos), 320);
        chk("ar_y",   int'(y_pos), 240);
        chk("ar_dx",  int'($signed(dx)), 0);
        chk("ar_dy",  int'($signed(dy)), 0);
        chk("ar_ovf", int'(ovf), 0);
        idle(1);
        rst_n = 1'b1;
        idle(1);
        mark();
        drive(8'h01); drive(8'h01);
        idle(2);
        chk("ar_dropped", pkt_cnt - pkt_base, 0);
        chk("ar_resync",  err_cnt - err_base, 2);

        drive(8'h28); drive(8'h00); drive(8'h00);
        chk("ysat_dy", int'($signed(dy)), -256);
        chk("ysat_y",  int'(y_pos), 479);
        idle(1);

        // Two packets with no idle cycle between them.
        mark();
        drive(8'h08); drive(8'hFF); drive(8'h00);
        chk("b2b_x1", int'(x_pos), 575);
        drive(8'h08); drive(8'hFF); drive(8'h00);
        chk("b2b_x2_sat", int'(x_pos), 639);
        chk("b2b_y",      int'(y_pos), 479);
        idle(1);
        chk("b2b_pkts", pkt_cnt - pkt_base, 2);
        chk("b2b_errs", err_cnt - err_base, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
